gray_frame_seq: RTL

GRAY_FRAME_SEQ -- requirements
Module: gray_frame_seq

---
 rtl/gray_pkg.sv | 14 +
 rtl/gray_frame_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/gray_pkg.sv
// Shared types for the grayscale frame sequencer: FSM state, RGB888 and gray pixel types.
package gray_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef logic [23:0] rgb_t;
  typedef logic [7:0]  gray_t;

endpackage

// File: rtl/gray_frame_seq.sv
// Streams one RGB frame through an external in-order grayscale converter into a gray buffer.
// Optional 16-bit completed-frame counter when GRAY_FRAME_SEQ_CNT_EN is defined.
module gray_frame_seq
  import gray_pkg::*;
#(
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned IMG_H        = 480,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              conv_valid,
  output logic [23:0]       conv_rgb,
  input  logic              gray_valid,
  input  logic [7:0]        gray_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
`ifdef GRAY_FRAME_SEQ_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam longint unsigned TotalPix = longint'(IMG_W) * longint'(IMG_H);
  localparam int unsigned     InflW    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(TotalPix - 1);
  localparam logic [InflW-1:0]  MaxInfl  = InflW'(MAX_INFLIGHT);

  if (TotalPix == 0 || TotalPix > (64'd1 << ADDR_W)) begin : g_size_check
    $error("gray_frame_seq: IMG_W*IMG_H must be in 1..2**ADDR_W");
  end
  if (MAX_INFLIGHT == 0) begin : g_inflight_check
    $error("gray_frame_seq: MAX_INFLIGHT must be at least 1");
  end

  state_e            state_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [InflW-1:0]  inflight_q;
  logic              conv_valid_q;
  logic              wr_done_q;

  logic  active;
  logic  issue;
  logic  accept;
  logic  last_wr;
  rgb_t  pix;
  gray_t gpix;

  // Counters stay ADDR_W wide; completion is tracked on the last address so a
  // frame filling the whole address space still terminates.
  always_comb begin
    active  = (state_q == StRun) || (state_q == StDrain);
    issue   = !rst && (state_q == StRun) && (inflight_q < MaxInfl);
    accept  = !rst && active && gray_valid;
    last_wr = accept && (wr_cnt_q == LastAddr);
    pix     = rd_data;
    gpix    = gray_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      inflight_q   <= '0;
      conv_valid_q <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      conv_valid_q <= issue;

      if (issue) begin
        rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
      end
      if (accept) begin
        wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
      end
      if (last_wr) begin
        wr_done_q <= 1'b1;
      end

      // A read and a result in the same cycle cancel out.
      case ({issue, accept})
        2'b10: inflight_q <= inflight_q + InflW'(1);
        2'b01: begin
          if (inflight_q != '0) begin
            inflight_q <= inflight_q - InflW'(1);
          end
        end
        default: ;
      endcase

      case (state_q)
        StIdle: begin
          if (start) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= '0;
            wr_done_q  <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (issue && (rd_cnt_q == LastAddr)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (wr_done_q || last_wr) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced low while rst is high, even before the reset edge.
  always_comb begin
    busy       = !rst && active;
    done       = !rst && (state_q == StDone);
    rd_en      = issue;
    rd_addr    = issue ? rd_cnt_q : '0;
    conv_valid = !rst && conv_valid_q;
    conv_rgb   = conv_valid ? pix : '0;
    wr_en      = accept;
    wr_addr    = accept ? wr_cnt_q : '0;
    wr_data    = accept ? gpix : '0;
  end

`ifdef GRAY_FRAME_SEQ_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (state_q == StDone) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = rst ? '0 : frame_cnt_q;
`endif

endmodule
